// File: rtl/mem_arb_n.sv
// mem_arb_n: N-channel memory arbiter that owns a single downstream port.
// A two-state FSM picks a winner while IDLE (fixed priority or round-robin),
// holds the grant for one transfer while BUSY, then inserts one bubble
// cycle before the next arbitration. The owning channel's address, data
// and strobes are muxed live onto the downstream port. Configurations must
// keep 2**IDW >= N so that every channel index fits in grant_id.
module mem_arb_n #(
    parameter int N    = 2,
    parameter int MODE = 1,
    parameter int IDW  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      req_valid,
    output logic [N-1:0]      req_ready,
    input  logic [32*N-1:0]   req_addr,
    input  logic [32*N-1:0]   req_wdata,
    input  logic [4*N-1:0]    req_wstrb,
    output logic [31:0]       req_rdata,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic [31:0]       mem_rdata,
    output logic [IDW-1:0]    grant_id,
    output logic              busy
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    logic [0:0]     r_state;
    logic [IDW-1:0] r_grant;
    logic [IDW-1:0] r_last;

    logic           w_busy;
    logic           w_own_valid;
    logic           w_mem_valid;
    logic [31:0]    w_addr;
    logic [31:0]    w_wdata;
    logic [3:0]     w_wstrb;
    logic [N-1:0]   w_req_ready;
    logic [IDW-1:0] w_win_fx;
    logic [IDW-1:0] w_win_rr;
    logic [IDW-1:0] w_winner;

    assign w_busy = (r_state == S_BUSY);

    // Fixed priority: scanning downward lets the lowest asserted index win last.
    always_comb begin
        w_win_fx = {IDW{1'b0}};
        for (int i = N - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                w_win_fx = IDW'(i);
            end else begin
                w_win_fx = w_win_fx;
            end
        end
    end

    // Round-robin: lowest requester above r_last wins; otherwise wrap to the lowest at or below it.
    always_comb begin
        w_win_rr = {IDW{1'b0}};
        for (int i = N - 1; i >= 0; i--) begin
            if (req_valid[i] && (IDW'(i) <= r_last)) begin
                w_win_rr = IDW'(i);
            end else begin
                w_win_rr = w_win_rr;
            end
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (req_valid[i] && (IDW'(i) > r_last)) begin
                w_win_rr = IDW'(i);
            end else begin
                w_win_rr = w_win_rr;
            end
        end
    end

    assign w_winner = (MODE == 0) ? w_win_fx : w_win_rr;

    // AND-OR mux of the owning channel's request fields, plus its one-hot ready pulse.
    always_comb begin
        w_own_valid = 1'b0;
        w_addr      = 32'h0000_0000;
        w_wdata     = 32'h0000_0000;
        w_wstrb     = 4'b0000;
        for (int i = 0; i < N; i++) begin
            w_own_valid = w_own_valid | ((r_grant == IDW'(i)) & req_valid[i]);
            w_addr      = w_addr  | ({32{r_grant == IDW'(i)}} & req_addr[32*i +: 32]);
            w_wdata     = w_wdata | ({32{r_grant == IDW'(i)}} & req_wdata[32*i +: 32]);
            w_wstrb     = w_wstrb | ({4{r_grant == IDW'(i)}}  & req_wstrb[4*i +: 4]);
        end
        w_mem_valid = w_busy & w_own_valid;
        for (int i = 0; i < N; i++) begin
            w_req_ready[i] = (r_grant == IDW'(i)) & w_mem_valid & mem_ready;
        end
    end

    // Grant FSM: arbitrate in IDLE, leave BUSY on completion or when the owner drops its request.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_grant <= {IDW{1'b0}};
            r_last  <= IDW'(N - 1);
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (|req_valid) begin
                        r_grant <= w_winner;
                        r_last  <= w_winner;
                        r_state <= S_BUSY;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_BUSY: begin
                    if (!w_own_valid || mem_ready) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_BUSY;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready = w_req_ready;
    assign req_rdata = mem_rdata;
    assign mem_valid = w_mem_valid;
    assign mem_addr  = w_addr;
    assign mem_wdata = w_wdata;
    assign mem_wstrb = w_busy ? w_wstrb : 4'b0000;
    assign grant_id  = r_grant;
    assign busy      = w_busy;

endmodule

// File: tb/tb_mem_arb_n.sv
// Directed bench for mem_arb_n: a per-cycle vector table on an N=2
// round-robin instance, plus grant-order sequences on N=4 instances in
// round-robin and fixed-priority modes.
module tb_mem_arb_n;

    logic clk;
    logic rst;
    logic rst4;

    // N=2, MODE=1 instance signals
    logic [1:0]  rv_a;
    logic [1:0]  rr_a;
    logic [63:0] addr_in_a;
    logic [63:0] wdata_in_a;
    logic [7:0]  wstrb_in_a;
    logic [31:0] rdata_a;
    logic        mv_a;
    logic        mr_a;
    logic [31:0] addr_a;
    logic [31:0] wdata_a;
    logic [3:0]  wstrb_a;
    logic [31:0] mrdata_a;
    logic [2:0]  gid_a;
    logic        busy_a;

    // N=4 instances (B: round-robin, C: fixed priority)
    logic [3:0]   rv_b, rv_c;
    logic [3:0]   rr_b, rr_c;
    logic [127:0] zero128;
    logic [15:0]  zero16;
    logic [31:0]  rdata_b, rdata_c;
    logic         mv_b, mv_c;
    logic         mr4;
    logic [31:0]  addr_b, addr_c, wdata_b, wdata_c;
    logic [3:0]   wstrb_b, wstrb_c;
    logic [2:0]   gid_b, gid_c;
    logic         busy_b, busy_c;

    int total;
    int bad;

    mem_arb_n #(.N(2), .MODE(1), .IDW(3)) u_dut_a (
        .clk(clk), .rst(rst), .req_valid(rv_a), .req_ready(rr_a),
        .req_addr(addr_in_a), .req_wdata(wdata_in_a), .req_wstrb(wstrb_in_a),
        .req_rdata(rdata_a), .mem_valid(mv_a), .mem_ready(mr_a),
        .mem_addr(addr_a), .mem_wdata(wdata_a), .mem_wstrb(wstrb_a),
        .mem_rdata(mrdata_a), .grant_id(gid_a), .busy(busy_a)
    );

    mem_arb_n #(.N(4), .MODE(1), .IDW(3)) u_dut_b (
        .clk(clk), .rst(rst4), .req_valid(rv_b), .req_ready(rr_b),
        .req_addr(zero128), .req_wdata(zero128), .req_wstrb(zero16),
        .req_rdata(rdata_b), .mem_valid(mv_b), .mem_ready(mr4),
        .mem_addr(addr_b), .mem_wdata(wdata_b), .mem_wstrb(wstrb_b),
        .mem_rdata(32'h0000_0000), .grant_id(gid_b), .busy(busy_b)
    );

    mem_arb_n #(.N(4), .MODE(0), .IDW(3)) u_dut_c (
        .clk(clk), .rst(rst4), .req_valid(rv_c), .req_ready(rr_c),
        .req_addr(zero128), .req_wdata(zero128), .req_wstrb(zero16),
        .req_rdata(rdata_c), .mem_valid(mv_c), .mem_ready(mr4),
        .mem_addr(addr_c), .mem_wdata(wdata_c), .mem_wstrb(wstrb_c),
        .mem_rdata(32'h0000_0000), .grant_id(gid_c), .busy(busy_c)
    );

    typedef struct {
        logic        rst;
        logic [1:0]  rv;
        logic        mr;
        logic [31:0] rd;
        logic        mv;
        logic [1:0]  rr;
        logic        bz;
        logic [2:0]  gid;
        logic [31:0] addr;
        logic [3:0]  ws;
    } vec_t;

    vec_t tv [19];

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    // Stimulus and checking
    initial begin
        int nb;
        int nc;
        logic [2:0] exp_b [5];
        logic [3:0] onehot;

        total = 0;
        bad   = 0;
        // ch0: read of 0x100; ch1: write 0xCAFEF00D to 0x2000 with strobes 0011
        addr_in_a  = {32'h0000_2000, 32'h0000_0100};
        wdata_in_a = {32'hCAFE_F00D, 32'h1111_1111};
        wstrb_in_a = {4'b0011, 4'b0000};
        zero128    = 128'd0;
        zero16     = 16'd0;
        rst   = 1'b1;
        rst4  = 1'b1;
        rv_a  = 2'b00;
        mr_a  = 1'b0;
        mrdata_a = 32'h0000_0000;
        rv_b  = 4'b0000;
        rv_c  = 4'b0000;
        mr4   = 1'b0;

        //        rst   rv     mr    rd             mv    rr     bz    gid   addr           ws
        tv[0]  = '{1'b0, 2'b00, 1'b0, 32'h0000_0000, 1'b0, 2'b00, 1'b0, 3'd0, 32'h0000_0100, 4'b0000};
        tv[1]  = '{1'b0, 2'b01, 1'b0, 32'h0000_0000, 1'b0, 2'b00, 1'b0, 3'd0, 32'h0000_0100, 4'b0000};
        tv[2]  = '{1'b0, 2'b01, 1'b0, 32'h0000_0000, 1'b1, 2'b00, 1'b1, 3'd0, 32'h0000_0100, 4'b0000};
        tv[3]  = '{1'b0, 2'b01, 1'b1, 32'hDEAD_BEEF, 1'b1, 2'b01, 1'b1, 3'd0, 32'h0000_0100, 4'b0000};
        tv[4]  = '{1'b0, 2'b00, 1'b0, 32'hDEAD_BEEF, 1'b0, 2'b00, 1'b0, 3'd0, 32'h0000_0100, 4'b0000};
        tv[5]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0000, 1'b0, 2'b00, 1'b0, 3'd0, 32'h0000_0100, 4'b0000};
        tv[6]  = '{1'b0, 2'b11, 1'b0, 32'h0000_0000, 1'b1, 2'b00, 1'b1, 3'd1, 32'h0000_2000, 4'b0011};
        tv[7]  = '{1'b0, 2'b11, 1'b1, 32'h1234_5678, 1'b1, 2'b10, 1'b1, 3'd1, 32'h0000_2000, 4'b0011};
        tv[8]  = '{1'b0, 2'b11, 1'b1, 32'h0000_0000, 1'b0, 2'b00, 1'b0, 3'd1, 32'h0000_2000, 4'b0000};
        tv[9]  = '{1'b0, 2'b01, 1'b0, 32'h0000_0000, 1'b1, 2'b00, 1'b1, 3'd0, 32'h0000_0100, 4'b0000};
        tv[10] = '{1'b0, 2'b00, 1'b0, 32'h0000_0000, 1'b0, 2'b00, 1'b1, 3'd0, 32'h0000_0100, 4'b0000};
        tv[11] = '{1'b0, 2'b00, 1'b1, 32'h0000_0000, 1'b0, 2'b00, 1'b0, 3'd0, 32'h0000_0100, 4'b0000};
        tv[12] = '{1'b0, 2'b10, 1'b0, 32'h0000_0000, 1'b0, 2'b00, 1'b0, 3'd0, 32'h0000_0100, 4'b0000};
        tv[13] = '{1'b0, 2'b10, 1'b1, 32'h0000_0000, 1'b1, 2'b10, 1'b1, 3'd1, 32'h0000_2000, 4'b0011};
        tv[14] = '{1'b0, 2'b01, 1'b0, 32'h0000_0000, 1'b0, 2'b00, 1'b0, 3'd1, 32'h0000_2000, 4'b0000};
        tv[15] = '{1'b1, 2'b01, 1'b0, 32'h0000_0000, 1'b1, 2'b00, 1'b1, 3'd0, 32'h0000_0100, 4'b0000};
        tv[16] = '{1'b0, 2'b11, 1'b1, 32'h0000_0000, 1'b0, 2'b00, 1'b0, 3'd0, 32'h0000_0100, 4'b0000};
        tv[17] = '{1'b0, 2'b11, 1'b0, 32'h0000_0000, 1'b1, 2'b00, 1'b1, 3'd0, 32'h0000_0100, 4'b0000};
        tv[18] = '{1'b0, 2'b00, 1'b0, 32'h0000_0000, 1'b0, 2'b00, 1'b1, 3'd0, 32'h0000_0100, 4'b0000};

        repeat (2) @(posedge clk);

        // Each row covers one clock period: drive at negedge, check the combinational view.
        for (int r = 0; r < 19; r++) begin
            @(negedge clk);
            rst      = tv[r].rst;
            rv_a     = tv[r].rv;
            mr_a     = tv[r].mr;
            mrdata_a = tv[r].rd;
            #1;
            chk("mem_valid", r, {31'd0, mv_a}, {31'd0, tv[r].mv});
            chk("req_ready", r, {30'd0, rr_a}, {30'd0, tv[r].rr});
            chk("busy", r, {31'd0, busy_a}, {31'd0, tv[r].bz});
            if (tv[r].bz) begin
                chk("grant_id", r, {29'd0, gid_a}, {29'd0, tv[r].gid});
                chk("mem_addr", r, addr_a, tv[r].addr);
                chk("mem_wdata", r, wdata_a, (tv[r].gid == 3'd1) ? 32'hCAFE_F00D : 32'h1111_1111);
            end else begin
                chk("grant_id_idle", r, {29'd0, gid_a}, {29'd0, tv[r].gid});
            end
            chk("mem_wstrb", r, {28'd0, wstrb_a}, {28'd0, tv[r].ws});
            chk("req_rdata", r, rdata_a, tv[r].rd);
        end

        // N=4 sequences: all four request (round-robin), channels 1 and 3 request (fixed priority).
        exp_b[0] = 3'd0; exp_b[1] = 3'd1; exp_b[2] = 3'd2; exp_b[3] = 3'd3; exp_b[4] = 3'd0;
        nb = 0;
        nc = 0;
        @(negedge clk);
        rst  = 1'b0;
        rv_a = 2'b00;
        mr_a = 1'b0;
        #1;
        chk("b_reset_busy", 0, {31'd0, busy_b}, 32'd0);
        chk("c_reset_gid", 0, {29'd0, gid_c}, 32'd0);
        rst4 = 1'b0;
        rv_b = 4'b1111;
        rv_c = 4'b1010;
        mr4  = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            #1;
            if (mv_b && mr4 && nb < 5) begin
                chk("rr_grant", nb, {29'd0, gid_b}, {29'd0, exp_b[nb]});
                onehot = 4'b0001 << exp_b[nb];
                chk("rr_ready", nb, {28'd0, rr_b}, {28'd0, onehot});
                nb++;
            end
            if (mv_c && mr4 && nc < 5) begin
                chk("fx_grant", nc, {29'd0, gid_c}, 32'd1);
                chk("fx_ready", nc, {28'd0, rr_c}, 32'h0000_0002);
                nc++;
            end
            if (nb >= 5 && nc >= 5) break;
        end
        chk("rr_grant_count", 0, nb, 32'd5);
        chk("fx_grant_count", 0, nc, 32'd5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
